// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants, types and the forwarding-select helper for the
// pipeline hazard unit.
package hazard_pkg;

  localparam int REG_W    = 5;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 3;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Pick the youngest producer of src: M beats W, register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input reg_idx_t src,
    input logic     wr_m,
    input reg_idx_t dst_m,
    input logic     wr_w,
    input reg_idx_t dst_w
  );
    if ((src != '0) && wr_m && (src == dst_m)) return FWD_M;
    if ((src != '0) && wr_w && (src == dst_w)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/load_scoreboard.sv
// load_scoreboard: one small down-counter per architectural register tracking
// how many more cycles a pending load result stays unavailable to the D stage.
module load_scoreboard
  import hazard_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic     clk_i,
  input  logic     clr_i,
  input  logic     load_i,
  input  reg_idx_t load_reg_i,
  input  reg_idx_t rs_i,
  input  reg_idx_t rt_i,
  output logic     rs_busy_o,
  output logic     rt_busy_o
);

  localparam cnt_t MEM_LAT_V = cnt_t'(MEM_LAT);

  cnt_t cnt_q [NUM_REGS];
  cnt_t cnt_d [NUM_REGS];

  // Age every live entry by one cycle; a new load to the same register wins.
  always_comb begin
    // NOTE: every entry gets a value before any conditional override, so no
    // path through this block leaves cnt_d unassigned and no latch is inferred.
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - cnt_t'(1) : '0;
    end
    if (load_i && (load_reg_i != '0)) begin
      cnt_d[load_reg_i] = MEM_LAT_V;
    end
    cnt_d[0] = '0;
  end

  // Counter array update; clear aborts all in-flight load tracking.
  always_ff @(posedge clk_i) begin
    // NOTE: this array is control state, not data storage: a stale nonzero
    // entry would stall the pipeline, so every entry is cleared on reset.
    // NOTE: sequential state is written with non-blocking assignments only,
    // so all flops see pre-edge values regardless of evaluation order.
    if (clr_i) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rs_busy_o = (rs_i != '0) && (cnt_q[rs_i] != '0);
  assign rt_busy_o = (rt_i != '0) && (cnt_q[rt_i] != '0);

endmodule

// File: rtl/mem_lat_hazard_unit.sv
// mem_lat_hazard_unit: forwarding selects and stall/flush control for a
// five-stage pipeline whose data memory takes MEM_LAT extra cycles.
// Optional feature: define HZ_STALL_CNT_EN to add the 32-bit StallCnt output.
module mem_lat_hazard_unit
  import hazard_pkg::*;
#(
  parameter int MEM_LAT  = 2,
  parameter int BR_FLUSH = 2
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic             BranchD,
  input  logic             MemtoRegE,
  input  logic             MemWriteE,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE
`ifdef HZ_STALL_CNT_EN
  ,
  output logic [31:0]      StallCnt
`endif
);

  localparam cnt_t MEM_LAT_V = cnt_t'(MEM_LAT);
  localparam cnt_t BR_HOLD_V = cnt_t'(BR_FLUSH - 1);

  logic load_e, load_hit_e, rs_busy, rt_busy;
  logic mem_op_d, mem_op_e;
  logic dep_stall, mem_stall, br_stall, stall;
  cnt_t port_cnt_q, port_cnt_d;
  cnt_t br_cnt_q, br_cnt_d;

  assign ForwardAE = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
  assign ForwardBE = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);

  // A load sitting in E; WriteRegE is nonzero here, so a zero D specifier cannot match.
  assign load_e     = MemtoRegE & RegWriteE & (WriteRegE != '0);
  assign load_hit_e = load_e & ((WriteRegE == RsD) | (WriteRegE == RtD));

  load_scoreboard #(
    .MEM_LAT(MEM_LAT)
  ) u_load_scoreboard (
    .clk_i     (CLK),
    .clr_i     (CLR),
    .load_i    (load_e),
    .load_reg_i(WriteRegE),
    .rs_i      (RsD),
    .rt_i      (RtD),
    .rs_busy_o (rs_busy),
    .rt_busy_o (rt_busy)
  );

  assign mem_op_d  = MemtoRegD | MemWriteD;
  assign mem_op_e  = MemtoRegE | MemWriteE;

  assign dep_stall = load_hit_e | rs_busy | rt_busy;
  assign mem_stall = mem_op_d & (mem_op_e | (port_cnt_q > cnt_t'(1)));
  assign br_stall  = BranchD & (load_hit_e | rs_busy | rt_busy);
  assign stall     = dep_stall | mem_stall | br_stall;

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = PCSrcE | (br_cnt_q != '0) | stall;

  // Next-state for the memory-port busy counter and the branch flush hold.
  always_comb begin
    port_cnt_d = (port_cnt_q != '0) ? port_cnt_q - cnt_t'(1) : '0;
    if (mem_op_e) port_cnt_d = MEM_LAT_V;
    br_cnt_d = (br_cnt_q != '0) ? br_cnt_q - cnt_t'(1) : '0;
    if (PCSrcE) br_cnt_d = BR_HOLD_V;
  end

  // Port and branch counters, synchronously cleared.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      port_cnt_q <= '0;
      br_cnt_q   <= '0;
    end else begin
      port_cnt_q <= port_cnt_d;
      br_cnt_q   <= br_cnt_d;
    end
  end

`ifdef HZ_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles spent with the decode stage stalled.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_lat_hazard_unit.sv
// tb_mem_lat_hazard_unit: three hazard units with different latency/flush
// parameters share one stimulus stream; a timestamp-based reference model
// predicts every output each cycle, and directed sequences pin known counts.
module tb_mem_lat_hazard_unit;

  localparam int N = 3;
  localparam int LAT [N] = '{2, 0, 3};
  localparam int BRF [N] = '{2, 1, 4};
  localparam int NEVER = -100;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       MemtoRegD, MemWriteD, BranchD, MemtoRegE, MemWriteE;
  logic       RegWriteE, RegWriteM, RegWriteW, PCSrcE;

  logic [N-1:0] stall_f, stall_d, flush_e;
  logic [1:0]   fwd_a [N];
  logic [1:0]   fwd_b [N];
`ifdef HZ_STALL_CNT_EN
  logic [31:0]  stall_cnt [N];
`endif

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  mem_lat_hazard_unit #(.MEM_LAT(2), .BR_FLUSH(2)) dut0 (
    .CLK(CLK), .CLR(CLR), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .BranchD(BranchD),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .RegWriteE(RegWriteE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
`ifdef HZ_STALL_CNT_EN
    .StallCnt(stall_cnt[0]),
`endif
    .StallF(stall_f[0]), .StallD(stall_d[0]), .FlushE(flush_e[0]),
    .ForwardAE(fwd_a[0]), .ForwardBE(fwd_b[0])
  );

  mem_lat_hazard_unit #(.MEM_LAT(0), .BR_FLUSH(1)) dut1 (
    .CLK(CLK), .CLR(CLR), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .BranchD(BranchD),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .RegWriteE(RegWriteE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
`ifdef HZ_STALL_CNT_EN
    .StallCnt(stall_cnt[1]),
`endif
    .StallF(stall_f[1]), .StallD(stall_d[1]), .FlushE(flush_e[1]),
    .ForwardAE(fwd_a[1]), .ForwardBE(fwd_b[1])
  );

  mem_lat_hazard_unit #(.MEM_LAT(3), .BR_FLUSH(4)) dut2 (
    .CLK(CLK), .CLR(CLR), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .BranchD(BranchD),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .RegWriteE(RegWriteE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
`ifdef HZ_STALL_CNT_EN
    .StallCnt(stall_cnt[2]),
`endif
    .StallF(stall_f[2]), .StallD(stall_d[2]), .FlushE(flush_e[2]),
    .ForwardAE(fwd_a[2]), .ForwardBE(fwd_b[2])
  );

  // ---------------- reference model ----------------
  // Each pending event is kept as the last cycle index at which it still
  // holds; a register is busy in cycle c when c <= its busy_until.
  int          cyc = 0;
  bit          check_en = 1'b0;
  int          busy_until  [N][32];
  int          port_until  [N];
  int          flush_until [N];
  logic [31:0] m_scnt      [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic e_load();
    return MemtoRegE && RegWriteE && (WriteRegE != 5'd0);
  endfunction

  function automatic logic reg_hit(input int i, input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return (busy_until[i][r] >= cyc) || (e_load() && (WriteRegE == r));
  endfunction

  function automatic logic m_stall(input int i);
    logic dep, mem;
    dep = reg_hit(i, RsD) || reg_hit(i, RtD);
    mem = (MemtoRegD || MemWriteD) &&
          ((MemtoRegE || MemWriteE) || (cyc < port_until[i]));
    return dep || mem || (BranchD && dep);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (r != 5'd0 && RegWriteM && r == WriteRegM) return 2'b10;
    if (r != 5'd0 && RegWriteW && r == WriteRegW) return 2'b01;
    return 2'b00;
  endfunction

  // Compare all outputs at the falling edge, then advance the model across
  // the coming rising edge using the inputs that edge will sample.
  initial begin
    for (int i = 0; i < N; i++) begin
      for (int r = 0; r < 32; r++) busy_until[i][r] = NEVER;
      port_until[i]  = NEVER;
      flush_until[i] = NEVER;
      m_scnt[i]      = '0;
    end
    forever begin
      @(negedge CLK);
      for (int i = 0; i < N; i++) begin
        logic st, fl;
        st = m_stall(i);
        fl = PCSrcE || (flush_until[i] >= cyc) || st;
        if (check_en) begin
          check($sformatf("StallF[%0d]", i), 32'(stall_f[i]), 32'(st));
          check($sformatf("StallD[%0d]", i), 32'(stall_d[i]), 32'(st));
          check($sformatf("FlushE[%0d]", i), 32'(flush_e[i]), 32'(fl));
          check($sformatf("ForwardAE[%0d]", i), 32'(fwd_a[i]), 32'(m_fwd(RsE)));
          check($sformatf("ForwardBE[%0d]", i), 32'(fwd_b[i]), 32'(m_fwd(RtE)));
`ifdef HZ_STALL_CNT_EN
          check($sformatf("StallCnt[%0d]", i), stall_cnt[i], m_scnt[i]);
`endif
        end
        if (CLR) begin
          for (int r = 0; r < 32; r++) busy_until[i][r] = NEVER;
          port_until[i]  = NEVER;
          flush_until[i] = NEVER;
          m_scnt[i]      = '0;
        end else begin
          if (e_load()) busy_until[i][WriteRegE] = cyc + LAT[i];
          if (MemtoRegE || MemWriteE) port_until[i] = cyc + LAT[i];
          if (PCSrcE) flush_until[i] = cyc + BRF[i] - 1;
          if (st && m_scnt[i] != 32'hFFFF_FFFF) m_scnt[i] = m_scnt[i] + 32'd1;
        end
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  int nst [N];
  int nfl [N];

  task automatic idle();
    CLR = 1'b0;
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    MemtoRegD = 1'b0; MemWriteD = 1'b0; BranchD = 1'b0;
    MemtoRegE = 1'b0; MemWriteE = 1'b0; RegWriteE = 1'b0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_tally();
    for (int i = 0; i < N; i++) begin
      nst[i] = 0;
      nfl[i] = 0;
    end
  endtask

  task automatic tally();
    @(negedge CLK);
    for (int i = 0; i < N; i++) begin
      nst[i] += int'(stall_d[i]);
      nfl[i] += int'(flush_e[i]);
    end
  endtask

  task automatic settle();
    repeat (6) begin
      step();
      idle();
    end
  endtask

  initial begin
    idle();
    CLR = 1'b1;
    step();
    step();
    CLR = 1'b0;
    check_en = 1'b1;

    // Reset state with quiet inputs.
    @(negedge CLK);
    check("reset StallD", 32'(stall_d), 32'd0);
    check("reset FlushE", 32'(flush_e), 32'd0);
    check("reset ForwardAE", 32'(fwd_a[0]), 32'd0);

    // Load-use at distance 1: lw $8 in E, add $8 in D held while stalled.
    step(); idle();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8; RtD = 5'd9;
    clear_tally();
    tally();
    repeat (6) begin
      step();
      MemtoRegE = 1'b0; RegWriteE = 1'b0; WriteRegE = 5'd0;
      tally();
    end
    check("load-use stalls LAT2", 32'(nst[0]), 32'd3);
    check("load-use stalls LAT0", 32'(nst[1]), 32'd1);
    check("load-use stalls LAT3", 32'(nst[2]), 32'd4);

    // The add reaches E while the load result sits in W.
    step(); idle();
    RsE = 5'd8; RtE = 5'd9; RegWriteW = 1'b1; WriteRegW = 5'd8;
    @(negedge CLK);
    check("add in E ForwardAE", 32'(fwd_a[0]), 32'h1);
    check("add in E ForwardBE", 32'(fwd_b[0]), 32'h0);
    settle();

    // Load-use at distance 2 with an independent ALU op in between.
    step(); idle();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RsD = 5'd1; RtD = 5'd2;
    @(negedge CLK);
    check("dist2 indep StallD LAT0", 32'(stall_d[1]), 32'd0);
    step(); idle();
    RegWriteE = 1'b1; WriteRegE = 5'd3; RsD = 5'd8;
    @(negedge CLK);
    check("dist2 use StallD LAT0", 32'(stall_d[1]), 32'd0);
    check("dist2 use StallD LAT2", 32'(stall_d[0]), 32'd1);
    settle();

    // Forwarding priority and register 0.
    step(); idle();
    RegWriteM = 1'b1; WriteRegM = 5'd5; RegWriteW = 1'b1; WriteRegW = 5'd5;
    RsE = 5'd5; RtE = 5'd5;
    @(negedge CLK);
    check("fwd M priority A", 32'(fwd_a[0]), 32'h2);
    check("fwd M priority B", 32'(fwd_b[1]), 32'h2);
    step();
    RsE = 5'd0;
    @(negedge CLK);
    check("fwd reg0 A", 32'(fwd_a[0]), 32'h0);
    step();
    RsE = 5'd5; RegWriteM = 1'b0;
    @(negedge CLK);
    check("fwd W only A", 32'(fwd_a[2]), 32'h1);
    settle();

    // sw in E then lw in D: memory port contention.
    step(); idle();
    MemWriteE = 1'b1; MemtoRegD = 1'b1; RsD = 5'd3;
    clear_tally();
    tally();
    repeat (6) begin
      step();
      MemWriteE = 1'b0;
      tally();
    end
    check("port stalls LAT2", 32'(nst[0]), 32'd2);
    check("port stalls LAT0", 32'(nst[1]), 32'd1);
    check("port stalls LAT3", 32'(nst[2]), 32'd3);
    settle();

    // Taken branch: FlushE hold length.
    step(); idle();
    PCSrcE = 1'b1;
    clear_tally();
    tally();
    repeat (6) begin
      step();
      PCSrcE = 1'b0;
      tally();
    end
    check("flush cycles BR2", 32'(nfl[0]), 32'd2);
    check("flush cycles BR1", 32'(nfl[1]), 32'd1);
    check("flush cycles BR4", 32'(nfl[2]), 32'd4);
    settle();

    // Reset while a load-use stall is in progress.
    step(); idle();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
    @(negedge CLK);
    check("pre-clr StallD", 32'(stall_d), 32'b111);
    step();
    MemtoRegE = 1'b0; RegWriteE = 1'b0; WriteRegE = 5'd0; CLR = 1'b1;
    @(negedge CLK);
    check("during clr StallD", 32'(stall_d), 32'b101);
    step();
    CLR = 1'b0;
    @(negedge CLK);
    check("after clr StallD", 32'(stall_d), 32'b000);
    settle();

`ifdef HZ_STALL_CNT_EN
    // Exactly five stalled cycles, then clear.
    step(); idle();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    repeat (5) begin
      MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
      step();
    end
    idle();
    @(negedge CLK);
    check("StallCnt five", stall_cnt[0], 32'd5);
    check("StallCnt five LAT0", stall_cnt[1], 32'd5);
    step();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    @(negedge CLK);
    check("StallCnt cleared", stall_cnt[2], 32'd0);
    settle();
`endif

    // Randomized traffic over a small register window to force collisions.
    repeat (3000) begin
      step();
      CLR       = ($urandom_range(0, 99) == 0);
      RsD       = 5'($urandom_range(0, 3));
      RtD       = 5'($urandom_range(0, 3));
      RsE       = 5'($urandom_range(0, 3));
      RtE       = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3));
      WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      MemtoRegD = 1'($urandom_range(0, 1));
      MemWriteD = ($urandom_range(0, 3) == 0);
      BranchD   = ($urandom_range(0, 3) == 0);
      MemtoRegE = ($urandom_range(0, 2) == 0);
      MemWriteE = ($urandom_range(0, 4) == 0);
      RegWriteE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      PCSrcE    = ($urandom_range(0, 9) == 0);
    end
    step();
    idle();
    @(negedge CLK);
    @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_lat_hazard_unit.md
MEM_LAT_HAZARD_UNIT -- requirements
Module: mem_lat_hazard_unit

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2: extra data-memory cycles, legal range 0..7.
REQ-002 SHALL have parameter BR_FLUSH, default 2: cycles FlushE is held per taken branch, legal range 1..4.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port CLR, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW, each input, 5 bits: register specifiers.
REQ-006 SHALL have ports MemtoRegD, MemWriteD, BranchD, MemtoRegE, MemWriteE, RegWriteE, RegWriteM, RegWriteW, PCSrcE, each input, 1 bit: stage control.
REQ-007 SHALL have ports StallF, StallD, FlushE, each output, 1 bit: pipeline control.
REQ-008 SHALL have ports ForwardAE, ForwardBE, each output, 2 bits: E-operand select; 00 = RF, 01 = W, 10 = M.

Function
REQ-009 SHALL drive ForwardAE = 10 when RsE != 0, RegWriteM and RsE == WriteRegM; else 01 when RsE != 0, RegWriteW and RsE == WriteRegW; else 00. ForwardBE uses RtE in the same way.
REQ-010 SHALL hold a per-register load scoreboard of 32 counters, 3 bits each; register 0 never tracked.
REQ-011 SHALL load counter[WriteRegE] with MEM_LAT on any edge where MemtoRegE & RegWriteE & WriteRegE != 0; otherwise each nonzero counter decrements by 1 per cycle.
REQ-012 SHALL, if a load and the decrement target the same register in the same cycle, apply the load value.
REQ-013 SHALL assert dep_stall when (RsD or RtD) matches a nonzero counter, or when MemtoRegE & RegWriteE & WriteRegE != 0 & WriteRegE in {RsD, RtD}. A zero specifier never matches.
REQ-014 SHALL hold a memory-port counter port_cnt, 3 bits: loaded with MEM_LAT when MemtoRegE | MemWriteE; otherwise decremented when nonzero.
REQ-015 SHALL assert mem_stall when (MemtoRegD | MemWriteD) & ((MemtoRegE | MemWriteE) | port_cnt > 1).
REQ-016 SHALL assert br_stall when BranchD & (E-load match per REQ-013, or a nonzero counter on RsD/RtD).
REQ-017 SHALL drive StallF = StallD = dep_stall | mem_stall | br_stall, combinationally, in the same cycle.
REQ-018 SHALL hold a branch-flush counter br_cnt, loaded with BR_FLUSH-1 on PCSrcE, otherwise decremented when nonzero.
REQ-019 SHALL drive FlushE = PCSrcE | (br_cnt != 0) | StallD.
REQ-020 SHALL, with MEM_LAT = 0, give exactly one stall cycle for load-use at distance 1 and none at distance 2.
REQ-021 SHALL, with MEM_LAT = N, give N+1 stall cycles for load-use at distance 1.

Reset
REQ-022 SHALL, while CLR = 1, clear all scoreboard counters, port_cnt and br_cnt to 0 at the next edge, aborting in-flight tracking.
REQ-023 SHALL, once reset has taken effect, drive StallF, StallD, FlushE = 0 and ForwardAE, ForwardBE = 00 when inputs are inactive.

Configuration
REQ-024 SHALL, when macro HZ_STALL_CNT_EN is defined, add output StallCnt, 32 bits, counting cycles with StallD = 1, saturating at 0xFFFFFFFF and cleared by CLR.
REQ-025 SHALL, when HZ_STALL_CNT_EN is not defined, have no StallCnt port and no counter logic, with all other behaviour identical.

Structure
REQ-026 SHALL take constants REG_W = 5, FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10 from shared package hazard_pkg.
REQ-027 SHALL place the scoreboard (REQ-010..012 plus the match outputs for RsD/RtD) in sub-module load_scoreboard; all other logic stays in the top module.

Verification
REQ-028 SHALL cover: MEM_LAT=2; lw $8 in E, add using $8 in D -> StallD high for exactly 3 cycles, then ForwardAE = 01 when add reaches E.
REQ-029 SHALL cover: MEM_LAT=0; same sequence -> exactly 1 stall cycle; with one independent instruction between the load and the use -> 0 stalls.
REQ-030 SHALL cover: RegWriteM=1, WriteRegM=5; RegWriteW=1, WriteRegW=5; RsE=5 -> ForwardAE = 10; RsE=0 -> ForwardAE = 00.
REQ-031 SHALL cover: MEM_LAT=3; sw in E, then lw in D -> StallD for 3 cycles (E-op cycle plus port_cnt 3, 2).
REQ-032 SHALL cover: BR_FLUSH=2; PCSrcE pulse for 1 cycle -> FlushE high for 2 cycles. Also CLR asserted mid-stall -> StallD = 0 on the cycle after reset takes effect.
REQ-033 SHALL cover, with HZ_STALL_CNT_EN defined: 5 stall cycles -> StallCnt = 5; CLR -> StallCnt = 0.
